// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command front end: collects a 6-byte frame, issues one ALU operation,
// and returns the 16-bit result low byte first (or ERR_BYTE) over a ready/valid TX port.
module alu_cmd_sequencer #(
   parameter int          OP_WIDTH  = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hCC,
   parameter logic [7:0]  ERR_BYTE  = 8'hEE,
   parameter int          TIMEOUT   = 15
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [7:0]          RX_P_DATA,
   input  logic                RX_D_VLD,
   output logic [OP_WIDTH-1:0] ALU_OP_A,
   output logic [OP_WIDTH-1:0] ALU_OP_B,
   output logic [3:0]          ALU_FUN,
   output logic                ALU_EN,
   input  logic [OP_WIDTH-1:0] ALU_OUT,
   input  logic                ALU_OUT_VLD,
   output logic [7:0]          TX_P_DATA,
   output logic                TX_D_VLD,
   input  logic                TX_READY,
   output logic                BUSY
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, RX_FUN, RX_A0, RX_A1, RX_B0, RX_B1,
      ISSUE, WAIT_RES, TX_LO, TX_HI, TX_ERR
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [OP_WIDTH-1:0] result;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (RX_D_VLD && RX_P_DATA == SYNC_BYTE) state_nxt = RX_FUN;
         RX_FUN:   if (RX_D_VLD) state_nxt = (RX_P_DATA[7:4] != 4'h0) ? TX_ERR : RX_A0;
         RX_A0:    if (RX_D_VLD) state_nxt = RX_A1;
         RX_A1:    if (RX_D_VLD) state_nxt = RX_B0;
         RX_B0:    if (RX_D_VLD) state_nxt = RX_B1;
         RX_B1:    if (RX_D_VLD) state_nxt = ISSUE;
         ISSUE:    state_nxt = WAIT_RES;
         // cnt lags the cycle index after ALU_EN by one, so a flag on cycle TIMEOUT still wins
         WAIT_RES: begin
            if (ALU_OUT_VLD)                     state_nxt = TX_LO;
            else if (cnt == CW'(TIMEOUT - 1))    state_nxt = TX_ERR;
         end
         TX_LO:    if (TX_READY) state_nxt = TX_HI;
         TX_HI:    if (TX_READY) state_nxt = IDLE;
         TX_ERR:   if (TX_READY) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ALU_OP_A <= '0;
         ALU_OP_B <= '0;
         ALU_FUN  <= '0;
         result   <= '0;
         cnt      <= '0;
      end else begin
         unique case (state)
            RX_FUN:   if (RX_D_VLD && RX_P_DATA[7:4] == 4'h0) ALU_FUN <= RX_P_DATA[3:0];
            RX_A0:    if (RX_D_VLD) ALU_OP_A[7:0]          <= RX_P_DATA;
            RX_A1:    if (RX_D_VLD) ALU_OP_A[OP_WIDTH-1:8] <= RX_P_DATA;
            RX_B0:    if (RX_D_VLD) ALU_OP_B[7:0]          <= RX_P_DATA;
            RX_B1:    if (RX_D_VLD) ALU_OP_B[OP_WIDTH-1:8] <= RX_P_DATA;
            ISSUE:    cnt <= '0;
            WAIT_RES: begin
               if (ALU_OUT_VLD) result <= ALU_OUT;
               else             cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ALU_EN    = (state == ISSUE);
      BUSY      = (state != IDLE);
      TX_D_VLD  = 1'b0;
      TX_P_DATA = '0;
      unique case (state)
         TX_LO:  begin TX_D_VLD = 1'b1; TX_P_DATA = result[7:0];          end
         TX_HI:  begin TX_D_VLD = 1'b1; TX_P_DATA = result[OP_WIDTH-1:8]; end
         TX_ERR: begin TX_D_VLD = 1'b1; TX_P_DATA = ERR_BYTE;             end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: bench-side ALU model, TX bytes checked against a queue of expected bytes.
module tb_alu_cmd_sequencer;

   localparam int TIMEOUT = 15;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [15:0] ALU_OP_A, ALU_OP_B;
   logic [3:0]  ALU_FUN;
   logic        ALU_EN;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_READY = 1'b0;
   logic        BUSY;

   int tests_run = 0;
   int fails     = 0;
   int en_count  = 0;
   int alu_delay = 2;      // cycle index after ALU_EN at which the flag rises; 0 = never
   bit alu_shift = 1'b0;
   int cyc       = 0;
   logic [7:0] sb[$];

   alu_cmd_sequencer #(.OP_WIDTH(16), .SYNC_BYTE(8'hCC), .ERR_BYTE(8'hEE), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .ALU_OP_A(ALU_OP_A), .ALU_OP_B(ALU_OP_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // External ALU stand-in: registered result, flag raised alu_delay cycles after ALU_EN
   always @(posedge CLK) begin
      if (ALU_EN)                 cyc = 1;
      else if (cyc > 0 && cyc < 64) cyc = cyc + 1;
      ALU_OUT_VLD <= (alu_delay != 0) && (cyc == alu_delay);
      ALU_OUT     <= alu_shift ? (ALU_OP_A << 1) : (ALU_OP_A + ALU_OP_B);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      logic [7:0] exp_b;
      if (ALU_EN) en_count++;
      if (RST && TX_D_VLD && TX_READY) begin
         exp_b = 'x;
         if (sb.size() > 0) exp_b = sb.pop_front();
         chk("tx_byte", {24'h0, TX_P_DATA}, {24'h0, exp_b});
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] f, input logic [15:0] a, input logic [15:0] b);
      send(8'hCC); send(f);
      send(a[7:0]); send(a[15:8]);
      send(b[7:0]); send(b[15:8]);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (BUSY && n < 200) begin tick(); n++; end
      chk({tag, "_idle"}, {31'h0, BUSY}, 32'h0);
      chk({tag, "_sb_empty"}, sb.size(), 32'h0);
   endtask

   task automatic wait_tx(input string tag);
      int n = 0;
      while (!TX_D_VLD && n < 60) begin tick(); n++; end
      chk({tag, "_tx_seen"}, {31'h0, TX_D_VLD}, 32'h1);
   endtask

   initial begin
      int k;
      int en0;

      repeat (3) tick();
      chk("rst_op_a", {16'h0, ALU_OP_A}, 32'h0);
      chk("rst_op_b", {16'h0, ALU_OP_B}, 32'h0);
      chk("rst_fun",  {28'h0, ALU_FUN}, 32'h0);
      chk("rst_en",   {31'h0, ALU_EN}, 32'h0);
      chk("rst_tx",   {23'h0, TX_D_VLD, TX_P_DATA}, 32'h0);
      chk("rst_busy", {31'h0, BUSY}, 32'h0);
      RST = 1'b1;
      tick();

      // Normal add frame
      TX_READY = 1'b1; alu_delay = 2; alu_shift = 1'b0;
      en0 = en_count;
      sb.push_back(8'h35); sb.push_back(8'h12);
      send_frame(8'h00, 16'h1234, 16'h0001);
      chk("add_en",   {31'h0, ALU_EN}, 32'h1);
      chk("add_op_a", {16'h0, ALU_OP_A}, 32'h1234);
      chk("add_op_b", {16'h0, ALU_OP_B}, 32'h0001);
      chk("add_fun",  {28'h0, ALU_FUN}, 32'h0);
      tick();
      chk("add_en_pulse", {31'h0, ALU_EN}, 32'h0);
      wait_idle("add");
      chk("add_en_count", en_count - en0, 32'h1);

      // Shift with back-pressure
      TX_READY = 1'b0; alu_shift = 1'b1;
      sb.push_back(8'h02); sb.push_back(8'h00);
      send_frame(8'h09, 16'h8001, 16'h0000);
      chk("shl_fun", {28'h0, ALU_FUN}, 32'h9);
      wait_tx("shl");
      for (int i = 0; i < 5; i++) begin
         chk("shl_hold", {23'h0, TX_D_VLD, TX_P_DATA}, 32'h102);
         tick();
      end
      TX_READY = 1'b1;
      wait_idle("shl");
      alu_shift = 1'b0;

      // Garbage then malformed function byte
      en0 = en_count;
      send(8'h55); send(8'hAA);
      chk("garbage_busy", {31'h0, BUSY}, 32'h0);
      sb.push_back(8'hEE);
      send(8'hCC); send(8'h1F);
      wait_idle("badfun");
      chk("badfun_no_en", en_count - en0, 32'h0);

      // Timeout: ALU never answers
      alu_delay = 0;
      sb.push_back(8'hEE);
      send_frame(8'h00, 16'h0001, 16'h0001);
      chk("to_en", {31'h0, ALU_EN}, 32'h1);
      k = 0;
      while (!TX_D_VLD && k < 40) begin tick(); k++; end
      chk("to_latency", k, TIMEOUT + 1);
      wait_idle("to");

      // Flag on exactly cycle TIMEOUT is accepted
      alu_delay = TIMEOUT;
      sb.push_back(8'h10); sb.push_back(8'h00);
      send_frame(8'h00, 16'h000F, 16'h0001);
      k = 0;
      while (!TX_D_VLD && k < 40) begin tick(); k++; end
      chk("late_latency", k, TIMEOUT + 1);
      chk("late_byte", {24'h0, TX_P_DATA}, 32'h10);
      wait_idle("late");

      // Reset in the middle of a frame
      alu_delay = 2;
      send(8'hCC); send(8'h00); send(8'h34);
      RST = 1'b0;
      tick();
      chk("mid_rst_busy", {31'h0, BUSY}, 32'h0);
      chk("mid_rst_op_a", {16'h0, ALU_OP_A}, 32'h0);
      RST = 1'b1;
      tick();
      en0 = en_count;
      sb.push_back(8'h05); sb.push_back(8'h00);
      send_frame(8'h00, 16'h0002, 16'h0003);
      wait_idle("mid_rst");
      chk("mid_rst_en_count", en_count - en0, 32'h1);

      // Bytes during ISSUE/WAIT_RES/TX_LO are dropped
      alu_delay = 4; TX_READY = 1'b0;
      en0 = en_count;
      sb.push_back(8'h30); sb.push_back(8'h00);
      send_frame(8'h00, 16'h0010, 16'h0020);
      send(8'hCC); send(8'h00); send(8'h05); send(8'h00);
      wait_tx("drop");
      send(8'hCC); send(8'h00);
      chk("drop_lo_held", {23'h0, TX_D_VLD, TX_P_DATA}, 32'h130);
      TX_READY = 1'b1;
      wait_idle("drop");
      alu_delay = 2;
      sb.push_back(8'h02); sb.push_back(8'h00);
      send_frame(8'h00, 16'h0001, 16'h0001);
      wait_idle("after_drop");
      chk("drop_en_count", en_count - en0, 32'h2);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
